// File: rtl/lu_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter: opcodes,
// FSM state encoding and the round-robin winner selection.
package lu_arbiter_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // prio is the index of the requester that wins a tie.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic prio);
        if (r0 && r1) begin
            return prio;
        end
        return r1 && !r0;
    endfunction

endpackage

// File: rtl/lu_core.sv
// Combinational bitwise logic unit: op[0] selects within a group,
// op[1] selects between the inverting group {NAND, NOR} and {AND, OR}.
module lu_core #(
    parameter int W = 4
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic grp_inv;
            logic grp_pos;
            assign grp_inv = op[0] ? ~(a[gi] | b[gi]) : ~(a[gi] & b[gi]);
            assign grp_pos = op[0] ?  (a[gi] | b[gi]) :  (a[gi] & b[gi]);
            assign y[gi]   = op[1] ? grp_pos : grp_inv;
        end
    endgenerate

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter in front of a shared logic unit: grant in IDLE,
// compute in EXEC, present the registered result with valid in DONE.
module lu_arbiter
    import lu_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [W-1:0]     result,
    output logic             valid,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t             state_q;
    state_t             state_d;
    logic               prio_q;
    logic [1:0]         op_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               id_q;
    logic [W-1:0]       result_q;
    logic               rsp_id_q;
    logic [CNT_W-1:0]   op_count_q;
    logic [W-1:0]       core_y;
    logic               any_req;
    logic               winner;
    logic               grant;

    assign any_req = req0 | req1;
    assign winner  = pick_winner(req0, req1, prio_q);

    lu_core #(.W(W)) u_core (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (core_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are gated by reset so a request never wins against it.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        valid = 1'b0;
        busy  = (state_q != ST_IDLE);
        if (state_q == ST_IDLE && any_req && !reset) begin
            gnt0 = !winner;
            gnt1 = winner;
        end
        if (state_q == ST_DONE) begin
            valid = 1'b1;
        end
    end

    assign grant = gnt0 | gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            op_q       <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            result_q   <= '0;
            rsp_id_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            if (grant) begin
                id_q   <= winner;
                op_q   <= winner ? op1 : op0;
                a_q    <= winner ? a1 : a0;
                b_q    <= winner ? b1 : b0;
                prio_q <= !winner;
            end
            // Counting on entry to DONE lets a reset in EXEC cancel the increment.
            if (state_q == ST_EXEC) begin
                result_q   <= core_y;
                rsp_id_q   <= id_q;
                op_count_q <= op_count_q + 8'd1;
            end
        end
    end

    assign result   = result_q;
    assign rsp_id   = rsp_id_q;
    assign op_count = op_count_q;

endmodule
